// File: rtl/parity_rx.sv
// UART-style serial receiver with a 2-flop input synchronizer, selectable even/odd
// parity checking and framing-error detection. Outputs update together with a valid pulse.
module parity_rx #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rxd,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic             PAR_ODD  = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    // A result of 1 means the received word and parity bit disagree with the selected sense.
    function automatic logic parity_check(input logic [DATA_BITS-1:0] d, input logic p);
        return (^d) ^ p ^ PAR_ODD;
    endfunction

    state_t               state_r, state_s;
    logic                 sync1_r, rxs_r;
    logic [CNT_W-1:0]     cnt_r, cnt_s;
    logic [IDX_W-1:0]     idx_r, idx_s;
    logic [DATA_BITS-1:0] shift_r, shift_s;
    logic                 par_r, par_s;
    logic [DATA_BITS-1:0] data_r, data_s;
    logic                 valid_r, valid_s;
    logic                 perr_r, perr_s;
    logic                 ferr_r, ferr_s;
    logic                 busy_r, busy_s;

    // Next-state, bit timing and output-update logic.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r + CNT_W'(1);
        idx_s   = idx_r;
        shift_s = shift_r;
        par_s   = par_r;
        data_s  = data_r;
        valid_s = 1'b0;
        perr_s  = perr_r;
        ferr_s  = ferr_r;
        case (state_r)
            IDLE: begin
                cnt_s = '0;
                if (!rxs_r) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                // A start bit that is high again at mid-bit is treated as a glitch.
                if (cnt_r == CNT_HALF) begin
                    cnt_s = '0;
                    idx_s = '0;
                    if (rxs_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = DATA;
                    end
                end else begin
                    state_s = START;
                end
            end
            DATA: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s          = '0;
                    shift_s[idx_r] = rxs_r;
                    if (idx_r == IDX_LAST) begin
                        state_s = PARITY;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = DATA;
                end
            end
            PARITY: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    par_s   = rxs_r;
                    state_s = STOP;
                end else begin
                    state_s = PARITY;
                end
            end
            STOP: begin
                if (cnt_r == CNT_LAST) begin
                    cnt_s   = '0;
                    valid_s = 1'b1;
                    data_s  = shift_r;
                    perr_s  = parity_check(shift_r, par_r);
                    ferr_s  = ~rxs_r;
                    if (rxs_r) begin
                        state_s = IDLE;
                    end else begin
                        state_s = WAIT_HIGH;
                    end
                end else begin
                    state_s = STOP;
                end
            end
            WAIT_HIGH: begin
                cnt_s = '0;
                if (rxs_r) begin
                    state_s = IDLE;
                end else begin
                    state_s = WAIT_HIGH;
                end
            end
            default: begin
                cnt_s   = '0;
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State, synchronizer and output registers; reset overrides any frame in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            sync1_r <= 1'b1;
            rxs_r   <= 1'b1;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
            par_r   <= 1'b0;
            data_r  <= '0;
            valid_r <= 1'b0;
            perr_r  <= 1'b0;
            ferr_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            sync1_r <= rxd;
            rxs_r   <= sync1_r;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shift_r <= shift_s;
            par_r   <= par_s;
            data_r  <= data_s;
            valid_r <= valid_s;
            perr_r  <= perr_s;
            ferr_r  <= ferr_s;
            busy_r  <= busy_s;
        end
    end

    assign data       = data_r;
    assign valid      = valid_r;
    assign parity_err = perr_r;
    assign frame_err  = ferr_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: drives directed and random serial frames into an even- and an
// odd-parity receiver and compares every received frame with a bit-level reference.
module tb_parity_rx;

    localparam int CPB = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       rxd;
    logic [7:0] data_e, data_o;
    logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

    int n_checks = 0;
    int n_pass   = 0;

    // Records are {data, parity_err, frame_err}.
    logic [9:0] obs_e[$], obs_o[$], exp_e[$], exp_o[$];
    logic [7:0] last_data;

    always #5 clk = ~clk;

    parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(0)) dut (
        .clk(clk), .reset(reset), .rxd(rxd), .data(data_e), .valid(valid_e),
        .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));

    parity_rx #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .rxd(rxd), .data(data_o), .valid(valid_o),
        .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

    // Capture every valid pulse; a stretched pulse shows up as an extra record.
    always @(negedge clk) begin
        if (valid_e) obs_e.push_back({data_e, perr_e, ferr_e});
        if (valid_o) obs_o.push_back({data_o, perr_o, ferr_o});
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Send n line bits from an 11-bit frame image (bit 0 = start), one bit period each.
    task automatic send_raw(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            rxd = bits[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    // Send a full frame and, when a receiver should complete it, record the expected results.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input bit expect_it);
        logic [10:0] bits;
        int ones;
        bits = {s, p, d, 1'b0};
        ones = $countones(d) + int'(p);
        if (expect_it) begin
            exp_e.push_back({d, 1'((ones % 2) != 0), ~s});
            exp_o.push_back({d, 1'((ones % 2) == 0), ~s});
            last_data = d;
        end
        send_raw(bits, 11);
    endtask

    task automatic flush_and_check(input string tag);
        int n;
        rxd = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        check_eq({tag, "_cnt_even"}, obs_e.size(), exp_e.size());
        check_eq({tag, "_cnt_odd"}, obs_o.size(), exp_o.size());
        n = (obs_e.size() < exp_e.size()) ? obs_e.size() : exp_e.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_rec_even"}, obs_e[i], exp_e[i]);
        n = (obs_o.size() < exp_o.size()) ? obs_o.size() : exp_o.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_rec_odd"}, obs_o[i], exp_o[i]);
        obs_e.delete(); obs_o.delete(); exp_e.delete(); exp_o.delete();
        @(negedge clk);
        check_eq({tag, "_idle_busy"}, {busy_e, busy_o}, 2'b00);
        check_eq({tag, "_held_data"}, data_e, last_data);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] d;
        logic       p, s;
        last_data = 8'h00;
        rxd   = 1'b1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("reset_outs", {data_e, valid_e, perr_e, ferr_e, busy_e}, 12'h000);
        check_eq("reset_outs_odd", {data_o, valid_o, perr_o, ferr_o, busy_o}, 12'h000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        send_frame(8'hA5, 1'b0, 1'b1, 1'b1);
        flush_and_check("a5");
        send_frame(8'h01, 1'b0, 1'b1, 1'b1);
        flush_and_check("parity01");

        // Short low glitch: must start, then abandon the frame silently.
        rxd = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("glitch_busy", busy_e, 1'b1);
        @(posedge clk);
        #1;
        rxd = 1'b1;
        flush_and_check("glitch");
        send_frame(8'h3C, 1'b0, 1'b1, 1'b1);
        flush_and_check("after_glitch");

        // Stop bit low and line held low: one valid, receiver stays busy until the line rises.
        send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
        rxd = 1'b0;
        repeat (3 * CPB) @(posedge clk);
        @(negedge clk);
        check_eq("held_low_cnt", obs_e.size(), 1);
        check_eq("held_low_busy", busy_e, 1'b1);
        @(posedge clk);
        #1;
        flush_and_check("frame_err");
        send_frame(8'hC3, 1'b0, 1'b1, 1'b1);
        flush_and_check("after_ferr");

        // Reset during data bit 4.
        send_raw({1'b1, 1'b0, 8'h77, 1'b0}, 5);
        rxd = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_outs", {data_e, valid_e, perr_e, ferr_e, busy_e}, 12'h000);
        check_eq("abort_outs_odd", {data_o, valid_o, perr_o, ferr_o, busy_o}, 12'h000);
        last_data = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush_and_check("abort");
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1);
        flush_and_check("after_abort");

        send_frame(8'h12, 1'b0, 1'b1, 1'b1);
        send_frame(8'h34, 1'b1, 1'b1, 1'b1);
        flush_and_check("b2b");

        for (int k = 0; k < 24; k++) begin
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 7) != 0);
            send_frame(d, p, s, 1'b1);
            rxd = 1'b1;
            if (!s) begin
                repeat (CPB + $urandom_range(0, 8)) @(posedge clk);
            end else begin
                repeat ($urandom_range(0, 20)) @(posedge clk);
            end
            #1;
        end
        flush_and_check("random");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
